int_gen: RTL
============

INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 Parameter ACK_ADDR, default 32'h0000_7F20: word address whose store acknowledges the interrupt.
REQ-002 Parameter HOLDOFF, default 4: cycles of interrupt-low between an acknowledge and the next COUNT period, range 1..255.
REQ-003 Parameter MAX_WAIT, default 16'd1000: cycles in ASSERT without an acknowledge before err_timeout sets.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 m_int_addr  input  32  CPU store address routed to the interrupt generator.
REQ-007 m_int_byteen  input  4  CPU store byte enables; nonzero marks a store this cycle.
REQ-008 cfg_en  input  1  enables interrupt generation.
REQ-009 cfg_period  input  16  cycles from COUNT entry to interrupt assertion; 0 is treated as 1.
REQ-010 cfg_oneshot  input  1  when 1, return to IDLE after one acknowledged interrupt.
REQ-011 interrupt  output  1  level interrupt to the CPU's external interrupt input; registered.
REQ-012 irq_cnt  output  8  number of interrupts raised, wraps 255->0.
REQ-013 spurious_cnt  output  8  acknowledge stores seen outside ASSERT, saturates at 255.
REQ-014 err_timeout  output  1  sticky flag: MAX_WAIT exceeded in ASSERT.

Function
REQ-015 ack SHALL be (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 0), sampled at each rising edge; addr[1:0] ignored.
REQ-016 States SHALL be IDLE, COUNT, ASSERT, HOLDOFF; interrupt SHALL equal 1 exactly when state is ASSERT.
REQ-017 IDLE: if cfg_en=1 at edge E0 -> COUNT with cnt = max(cfg_period,1)-1; otherwise stay.
REQ-018 COUNT: at each edge, cfg_en=0 -> IDLE (abort, no interrupt); else cnt==0 -> ASSERT; else cnt decrements.
REQ-019 interrupt SHALL first read 1 after edge E0+max(cfg_period,1); cfg_period is sampled only at COUNT entry.
REQ-020 irq_cnt SHALL increment by 1 on every COUNT->ASSERT transition.
REQ-021 ASSERT: ack -> HOLDOFF with hcnt=HOLDOFF-1, interrupt low from that edge; cfg_en=0 SHALL NOT drop interrupt, only ack leaves ASSERT.
REQ-022 ASSERT: wait counter (16 bit) starts at 0 on entry and increments each edge without ack; when it reaches MAX_WAIT, err_timeout SHALL set and stay set; interrupt stays high; the counter holds at MAX_WAIT.
REQ-023 HOLDOFF: hcnt decrements each edge; at hcnt==0 -> COUNT (reload per REQ-017) if cfg_en=1 and cfg_oneshot=0, else IDLE.
REQ-024 ack in IDLE, COUNT or HOLDOFF SHALL increment spurious_cnt (saturating) and SHALL NOT change state or counters.
REQ-025 ack on the same edge that COUNT->ASSERT occurs SHALL count as spurious; acknowledge requires state ASSERT before the edge.
REQ-026 cfg_oneshot SHALL be sampled at HOLDOFF exit only.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state IDLE, interrupt=0, irq_cnt=0, spurious_cnt=0, err_timeout=0, and all internal counters to 0.
REQ-029 Reset asserted during ASSERT SHALL drop interrupt without an acknowledge; after release, operation restarts from IDLE per REQ-017.
REQ-030 First edge after reset release SHALL be evaluated as IDLE.

Verification
REQ-031 cfg_en=1, cfg_period=5, HOLDOFF=4, ack 3 cycles after interrupt rises -> interrupt high at E0+5, low the edge after ack, high again 4+5 edges later; irq_cnt=2.
REQ-032 cfg_period=0 -> interrupt high at E0+1; cfg_period=1 gives identical timing.
REQ-033 cfg_oneshot=1, period=3, one ack -> single pulse, state IDLE after HOLDOFF, irq_cnt=1, interrupt stays 0 for 50 cycles.
REQ-034 store to 0x7F24, then to 0x7F22 with byteen=4'b0000, then to 0x7F23 with byteen=4'b1000 during ASSERT -> first two ignored, third acknowledges.
REQ-035 300 acks during COUNT -> spurious_cnt=255, state and irq_cnt unaffected; no ack for MAX_WAIT=1000 cycles in ASSERT -> err_timeout=1, interrupt still 1.
REQ-036 reset pulsed mid-COUNT and mid-ASSERT (not edge-aligned) -> interrupt=0 and all counters 0 before the next clock edge.

Source files
------------

// File: rtl/int_gen_if.sv
// int_gen_if: CPU store bus and interrupt line between the CPU and int_gen
interface int_gen_if;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;
  modport master (output m_int_addr, m_int_byteen, input interrupt);
  modport slave  (input m_int_addr, m_int_byteen, output interrupt);
endinterface

// File: rtl/int_gen.sv
// int_gen: periodic level interrupt generator acknowledged by a CPU store to ACK_ADDR
module int_gen #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int          HOLDOFF  = 4,
  parameter logic [15:0] MAX_WAIT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  int_gen_if.slave    bus,
  input  logic        cfg_en,
  input  logic [15:0] cfg_period,
  input  logic        cfg_oneshot,
  output logic [7:0]  irq_cnt,
  output logic [7:0]  spurious_cnt,
  output logic        err_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ASSERT, S_HOLD} state_t;
  localparam logic [7:0] HCNT_INIT = 8'(HOLDOFF - 1);
  state_t      state, state_n;
  logic [15:0] cnt, wcnt, wcnt_n, cnt_load;
  logic [7:0]  hcnt;
  logic        ack, irq_inc, spur_inc;
  assign ack      = (bus.m_int_addr[31:2] == ACK_ADDR[31:2]) && |bus.m_int_byteen;
  // a zero period behaves as a one-cycle period
  assign cnt_load = cfg_period - 16'(cfg_period != 16'd0);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = cfg_en ? S_COUNT : S_IDLE;
      S_COUNT:  state_n = !cfg_en ? S_IDLE : (cnt == 16'd0 ? S_ASSERT : S_COUNT);
      S_ASSERT: state_n = ack ? S_HOLD : S_ASSERT;
      default:  state_n = hcnt != 8'd0 ? S_HOLD : (cfg_en && !cfg_oneshot ? S_COUNT : S_IDLE);
    endcase
  end
  always_comb begin
    irq_inc  = state == S_COUNT && state_n == S_ASSERT;
    spur_inc = ack && state != S_ASSERT && spurious_cnt != 8'hff;
    wcnt_n   = (state == S_ASSERT && !ack && wcnt != MAX_WAIT) ? wcnt + 16'd1 : wcnt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt           <= '0;
      hcnt          <= '0;
      wcnt          <= '0;
      bus.interrupt <= 1'b0;
      irq_cnt       <= '0;
      spurious_cnt  <= '0;
      err_timeout   <= 1'b0;
    end else begin
      bus.interrupt <= state_n == S_ASSERT;
      cnt           <= state_n == S_COUNT ? (state == S_COUNT ? cnt - 16'd1 : cnt_load) : cnt;
      hcnt          <= state_n == S_HOLD ? (state == S_HOLD ? hcnt - 8'd1 : HCNT_INIT) : hcnt;
      wcnt          <= irq_inc ? 16'd0 : wcnt_n;
      err_timeout   <= err_timeout | (state == S_ASSERT && wcnt_n == MAX_WAIT);
      irq_cnt       <= irq_cnt + 8'(irq_inc);
      spurious_cnt  <= spurious_cnt + 8'(spur_inc);
    end
endmodule
